// File: rtl/eth_pause_scheduler_if.sv
// Bundle of the MAC-facing flow-control signals for eth_pause_scheduler.
// The master side drives FIFO flags and controls; the slave side (the scheduler) returns pause requests.
interface eth_pause_scheduler_if;
    logic [1:0]  enable;
    logic        count_clear;
    logic        red_rx_a_full;
    logic        red_rx_a_empty;
    logic        black_rx_a_full;
    logic        black_rx_a_empty;
    logic        red_xoff_gen;
    logic        red_xon_gen;
    logic        black_xoff_gen;
    logic        black_xon_gen;
    logic [1:0]  paused;
    logic [15:0] red_xoff_count;
    logic [15:0] black_xoff_count;

    modport master (
        output enable, count_clear,
        output red_rx_a_full, red_rx_a_empty, black_rx_a_full, black_rx_a_empty,
        input  red_xoff_gen, red_xon_gen, black_xoff_gen, black_xon_gen,
        input  paused, red_xoff_count, black_xoff_count
    );

    modport slave (
        input  enable, count_clear,
        input  red_rx_a_full, red_rx_a_empty, black_rx_a_full, black_rx_a_empty,
        output red_xoff_gen, red_xon_gen, black_xoff_gen, black_xon_gen,
        output paused, red_xoff_count, black_xoff_count
    );
endinterface

// File: rtl/eth_pause_scheduler.sv
// Pause-frame scheduler for the red and black TSE MACs: debounced XOFF, periodic
// XOFF refresh while congested, XON on drain, and saturating per-channel XOFF counts.
module eth_pause_channel #(
    parameter int DEBOUNCE       = 8,
    parameter int PULSE_LEN      = 4,
    parameter int REFRESH_W      = 24,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        count_clear,
    input  logic        rx_a_full,
    input  logic        rx_a_empty,
    output logic        xoff_gen,
    output logic        xon_gen,
    output logic        paused,
    output logic [15:0] xoff_count
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    localparam logic [DW-1:0]        DB_MAX       = DW'(DEBOUNCE);
    localparam logic [DW-1:0]        DB_HIT       = DW'(DEBOUNCE - 1);
    localparam logic [PW-1:0]        PULSE_LAST   = PW'(PULSE_LEN - 1);
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        FLOW       = 2'd0,
        XOFF_PULSE = 2'd1,
        PAUSED     = 2'd2,
        XON_PULSE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        full_cnt_q, full_cnt_d;
    logic [DW-1:0]        empty_cnt_q, empty_cnt_d;
    logic [PW-1:0]        pulse_cnt_q, pulse_cnt_d;
    logic [REFRESH_W-1:0] timer_q, timer_d;
    logic [15:0]          xoff_count_d;

    logic full_hit;
    logic empty_hit;
    logic pulse_done;
    logic refresh_hit;
    logic state_change;
    logic xoff_entry;

    // A hit means the current sample is the DEBOUNCE-th consecutive one.
    assign full_hit    = rx_a_full && (full_cnt_q >= DB_HIT);
    assign empty_hit   = rx_a_empty && !rx_a_full && (empty_cnt_q >= DB_HIT);
    assign pulse_done  = (pulse_cnt_q == PULSE_LAST);
    assign refresh_hit = (timer_q == REFRESH_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FLOW:       if (enable && full_hit) state_d = XOFF_PULSE;
            XOFF_PULSE: if (pulse_done) state_d = PAUSED;
            PAUSED: begin
                if (!enable || empty_hit) state_d = XON_PULSE;
                else if (refresh_hit)     state_d = XOFF_PULSE;
            end
            XON_PULSE:  if (pulse_done) state_d = FLOW;
            default:    state_d = FLOW;
        endcase
    end

    assign state_change = (state_d != state_q);
    assign xoff_entry   = (state_d == XOFF_PULSE) && (state_q != XOFF_PULSE);

    // Every per-state counter restarts from zero whenever the state moves.
    always_comb begin
        full_cnt_d  = '0;
        empty_cnt_d = '0;
        pulse_cnt_d = '0;
        timer_d     = '0;
        if (!state_change) begin
            if (rx_a_full)
                full_cnt_d = (full_cnt_q == DB_MAX) ? full_cnt_q : full_cnt_q + DW'(1);
            if (rx_a_empty && !rx_a_full)
                empty_cnt_d = (empty_cnt_q == DB_MAX) ? empty_cnt_q : empty_cnt_q + DW'(1);
            if (state_q == XOFF_PULSE || state_q == XON_PULSE)
                pulse_cnt_d = pulse_cnt_q + PW'(1);
            if (state_q == PAUSED)
                timer_d = timer_q + REFRESH_W'(1);
        end
    end

    // A clear that coincides with a new XOFF keeps that XOFF in the count.
    assign xoff_count_d = count_clear                             ? {15'd0, xoff_entry}
                        : (xoff_entry && xoff_count != 16'hFFFF) ? xoff_count + 16'd1
                        :                                          xoff_count;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FLOW;
            full_cnt_q  <= '0;
            empty_cnt_q <= '0;
            pulse_cnt_q <= '0;
            timer_q     <= '0;
            xoff_gen    <= 1'b0;
            xon_gen     <= 1'b0;
            paused      <= 1'b0;
            xoff_count  <= '0;
        end else begin
            state_q     <= state_d;
            full_cnt_q  <= full_cnt_d;
            empty_cnt_q <= empty_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            timer_q     <= timer_d;
            xoff_gen    <= (state_d == XOFF_PULSE);
            xon_gen     <= (state_d == XON_PULSE);
            paused      <= (state_d == XOFF_PULSE) || (state_d == PAUSED);
            xoff_count  <= xoff_count_d;
        end
    end
endmodule

module eth_pause_scheduler #(
    parameter int DEBOUNCE       = 8,
    parameter int PULSE_LEN      = 4,
    parameter int REFRESH_W      = 24,
    parameter int REFRESH_CYCLES = 1000000
) (
    input logic                 clk,
    input logic                 reset,
    eth_pause_scheduler_if.slave bus
);
    logic red_paused;
    logic black_paused;

    eth_pause_channel #(
        .DEBOUNCE       (DEBOUNCE),
        .PULSE_LEN      (PULSE_LEN),
        .REFRESH_W      (REFRESH_W),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_red (
        .clk         (clk),
        .reset       (reset),
        .enable      (bus.enable[0]),
        .count_clear (bus.count_clear),
        .rx_a_full   (bus.red_rx_a_full),
        .rx_a_empty  (bus.red_rx_a_empty),
        .xoff_gen    (bus.red_xoff_gen),
        .xon_gen     (bus.red_xon_gen),
        .paused      (red_paused),
        .xoff_count  (bus.red_xoff_count)
    );

    eth_pause_channel #(
        .DEBOUNCE       (DEBOUNCE),
        .PULSE_LEN      (PULSE_LEN),
        .REFRESH_W      (REFRESH_W),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_black (
        .clk         (clk),
        .reset       (reset),
        .enable      (bus.enable[1]),
        .count_clear (bus.count_clear),
        .rx_a_full   (bus.black_rx_a_full),
        .rx_a_empty  (bus.black_rx_a_empty),
        .xoff_gen    (bus.black_xoff_gen),
        .xon_gen     (bus.black_xon_gen),
        .paused      (black_paused),
        .xoff_count  (bus.black_xoff_count)
    );

    assign bus.paused = {black_paused, red_paused};
endmodule

// File: tb/tb_eth_pause_scheduler.sv
// Directed bench for eth_pause_scheduler: a per-cycle vector table for the red
// channel lifecycle plus hand sequences for refresh, saturation, clears and reset.
module tb_eth_pause_scheduler;
    localparam int DEBOUNCE       = 4;
    localparam int PULSE_LEN      = 2;
    localparam int REFRESH_W      = 24;
    localparam int REFRESH_CYCLES = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    eth_pause_scheduler_if bus();

    eth_pause_scheduler #(
        .DEBOUNCE       (DEBOUNCE),
        .PULSE_LEN      (PULSE_LEN),
        .REFRESH_W      (REFRESH_W),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // gen = {red_xoff, red_xon, black_xoff, black_xon}
    typedef struct {
        logic [1:0]  en;
        logic        clr;
        logic        rf, re, bf, be;
        logic [3:0]  gen;
        logic [1:0]  pau;
        logic [15:0] rc, bc;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic [1:0] en, logic clr, logic rf, logic re, logic bf, logic be,
                                logic [3:0] gen, logic [1:0] pau, logic [15:0] rc, logic [15:0] bc);
        vec_t v;
        v.en = en; v.clr = clr; v.rf = rf; v.re = re; v.bf = bf; v.be = be;
        v.gen = gen; v.pau = pau; v.rc = rc; v.bc = bc;
        return v;
    endfunction

    function automatic logic [3:0] gens();
        return {bus.red_xoff_gen, bus.red_xon_gen, bus.black_xoff_gen, bus.black_xon_gen};
    endfunction

    function automatic logic [63:0] outs();
        return {26'd0, gens(), bus.paused, bus.red_xoff_count, bus.black_xoff_count};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] en, input logic clr, input logic rf, input logic re,
                         input logic bf, input logic be);
        bus.enable           = en;
        bus.count_clear      = clr;
        bus.red_rx_a_full    = rf;
        bus.red_rx_a_empty   = re;
        bus.black_rx_a_full  = bf;
        bus.black_rx_a_empty = be;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Row i drives inputs for one cycle; its expectation is the outputs after the next edge.
        // Glitching a_full: three high, one low, three times -> never reaches four samples.
        for (int rep = 0; rep < 3; rep++)
            for (int k = 0; k < 4; k++)
                vecs.push_back(mk(2'b11, 1'b0, (k != 3), 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 16'd0, 16'd0));
        // Steady a_full: XOFF on the 4th sample for two cycles, then PAUSED.
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 16'd0, 16'd0));
        vecs.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 2'b01, 16'd1, 16'd0));
        vecs.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 2'b01, 16'd1, 16'd0));
        vecs.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b01, 16'd1, 16'd0));
        // Both flags high in PAUSED: full wins, no XON.
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 16'd1, 16'd0));
        // a_empty alone for four samples -> XON for two cycles, then FLOW.
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 16'd1, 16'd0));
        vecs.push_back(mk(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 2'b00, 16'd1, 16'd0));
        vecs.push_back(mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 2'b00, 16'd1, 16'd0));
        vecs.push_back(mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 16'd1, 16'd0));
        // Red disabled in FLOW: a_full held high produces nothing.
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 16'd1, 16'd0));

        do_reset();
        check("reset_state", outs(), 64'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].rf, vecs[i].re, vecs[i].bf, vecs[i].be);
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {26'd0, vecs[i].gen, vecs[i].pau, vecs[i].rc, vecs[i].bc});
        end

        // Refresh: PAUSED entered at cycle 6, XOFF re-sent at cycle 26.
        do_reset();
        drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("first_xoff", {bus.red_xoff_gen, bus.red_xoff_count}, {1'b1, 16'd1});
        repeat (2) tick();
        check("paused_entry", {bus.red_xoff_gen, bus.paused}, {1'b0, 2'b01});
        repeat (19) tick();
        check("before_refresh", {63'd0, bus.red_xoff_gen}, 64'd0);
        tick();
        check("refresh_xoff", {bus.red_xoff_gen, bus.red_xoff_count}, {1'b1, 16'd2});
        tick();
        check("refresh_second", {63'd0, bus.red_xoff_gen}, 64'd1);
        tick();
        check("refresh_done", {bus.red_xoff_gen, bus.paused}, {1'b0, 2'b01});

        // Preload the counter to its ceiling, then let the next refresh (cycle 48) hit it.
        repeat (2) tick();
        force dut.u_red.xoff_count_d = 16'hFFFF;
        tick();
        release dut.u_red.xoff_count_d;
        check("preload", {48'd0, bus.red_xoff_count}, 64'hFFFF);
        repeat (17) tick();
        check("saturated_refresh", {bus.red_xoff_gen, bus.red_xoff_count}, {1'b1, 16'hFFFF});

        // Next refresh lands at cycle 70; clear it in the same cycle.
        repeat (21) tick();
        bus.count_clear = 1'b1;
        tick();
        bus.count_clear = 1'b0;
        check("clear_with_xoff", {bus.red_xoff_gen, bus.red_xoff_count}, {1'b1, 16'd1});
        repeat (2) tick();
        bus.count_clear = 1'b1;
        tick();
        bus.count_clear = 1'b0;
        check("clear_alone", {48'd0, bus.red_xoff_count}, 64'd0);

        // Both channels congested together, then black disabled while PAUSED.
        do_reset();
        drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) tick();
        check("both_xoff", {gens(), bus.paused}, {4'b1010, 2'b11});
        repeat (4) tick();
        bus.enable = 2'b01;
        tick();
        check("black_xon_1", {gens(), bus.paused}, {4'b0001, 2'b01});
        tick();
        check("black_xon_2", {gens(), bus.paused}, {4'b0001, 2'b01});
        tick();
        check("black_flow", outs(), {26'd0, 4'b0000, 2'b01, 16'd1, 16'd1});

        // Reset while XOFF is on the wire.
        do_reset();
        drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("pulse_before_reset", {63'd0, bus.red_xoff_gen}, 64'd1);
        reset = 1'b1;
        tick();
        check("reset_mid_pulse", outs(), 64'd0);
        reset = 1'b0;
        bus.red_rx_a_full = 1'b0;
        repeat (3) tick();
        check("no_xon_after_reset", outs(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
